// File: rtl/mem_wb_stage_if.sv
// M->W pipeline register bus: M-stage inputs, stage controls and the registered W-stage outputs.
// The stage uses the slave modport; the upstream driver and GRF side use master.
interface mem_wb_stage_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 stall;
  logic                 flush;

  logic                 M_valid;
  logic [31:0]          M_PC;
  logic [4:0]           M_rd_addr;
  logic                 M_reg_write;
  logic [1:0]           M_wb_sel;
  logic [31:0]          M_alu_result;
  logic [31:0]          M_dm_read_data;

  logic                 W_valid;
  logic [31:0]          W_PC;
  logic [4:0]           W_rd_addr;
  logic [31:0]          W_write_data;
  logic                 W_reg_write;
  logic                 W_new;
  logic [CNT_WIDTH-1:0] retired_cnt;

  modport master (
    output stall, flush,
    output M_valid, M_PC, M_rd_addr, M_reg_write, M_wb_sel, M_alu_result, M_dm_read_data,
    input  W_valid, W_PC, W_rd_addr, W_write_data, W_reg_write, W_new, retired_cnt
  );

  modport slave (
    input  stall, flush,
    input  M_valid, M_PC, M_rd_addr, M_reg_write, M_wb_sel, M_alu_result, M_dm_read_data,
    output W_valid, W_PC, W_rd_addr, W_write_data, W_reg_write, W_new, retired_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Write-back pipeline register: selects GRF write data at capture, handles stall/flush, counts retirements.
// Optional WB_TRACE_EN macro compiles in a per-instruction GRF write trace ($display).
module mem_wb_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_wb_stage_if.slave       bus
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  logic                 w_valid_q;
  logic [31:0]          w_pc_q;
  logic [4:0]           w_rd_addr_q;
  logic [31:0]          w_write_data_q;
  logic                 w_reg_write_q;
  logic                 w_new_q;
  logic [CNT_WIDTH-1:0] retired_cnt_q;

  logic [31:0]          link_addr;
  logic [31:0]          wb_data;
  logic                 grf_we;

  // Link address wraps naturally in 32 bits (FFFF_FFFC -> 0000_0004).
  assign link_addr = bus.M_PC + 32'd8;
  assign grf_we    = bus.M_valid & bus.M_reg_write & (bus.M_rd_addr != 5'd0);

  always_comb begin
    wb_data = 32'h0;
    case (wb_sel_e'(bus.M_wb_sel))
      WB_ALU:  wb_data = bus.M_alu_result;
      WB_MEM:  wb_data = bus.M_dm_read_data;
      WB_LINK: wb_data = link_addr;
      WB_RSVD: wb_data = 32'h0;
      default: wb_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q      <= 1'b0;
      w_pc_q         <= RESET_PC;
      w_rd_addr_q    <= 5'd0;
      w_write_data_q <= 32'h0;
      w_reg_write_q  <= 1'b0;
      w_new_q        <= 1'b0;
      retired_cnt_q  <= '0;
    end else if (bus.flush) begin
      // Bubble keeps the M PC so W_PC still tracks program position.
      w_valid_q      <= 1'b0;
      w_pc_q         <= bus.M_PC;
      w_rd_addr_q    <= 5'd0;
      w_write_data_q <= 32'h0;
      w_reg_write_q  <= 1'b0;
      w_new_q        <= 1'b0;
    end else if (bus.stall) begin
      w_new_q        <= 1'b0;
    end else begin
      w_valid_q      <= bus.M_valid;
      w_pc_q         <= bus.M_PC;
      w_rd_addr_q    <= bus.M_rd_addr;
      w_write_data_q <= wb_data;
      w_reg_write_q  <= grf_we;
      w_new_q        <= 1'b1;
      if (bus.M_valid) begin
        retired_cnt_q <= retired_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.W_valid      = w_valid_q;
  assign bus.W_PC         = w_pc_q;
  assign bus.W_rd_addr    = w_rd_addr_q;
  assign bus.W_write_data = w_write_data_q;
  assign bus.W_reg_write  = w_reg_write_q;
  assign bus.W_new        = w_new_q;
  assign bus.retired_cnt  = retired_cnt_q;

`ifdef WB_TRACE_EN
  // W_new is high for one cycle per instruction, so stalls never repeat a line.
  always @(posedge clk) begin
    if (w_new_q && w_reg_write_q) begin
      $display("%d@%h: $%d <= %h", $time, w_pc_q, w_rd_addr_q, w_write_data_q);
    end
  end
`else
`endif

endmodule
